// File: rtl/tmds_pkg.sv
// Shared constants and encodings for the TMDS period-aware receive decoder.
// TERC4 decode and data-island tracking are enabled by defining TMDS_TERC4_EN.
package tmds_pkg;

    // Control tokens, indexed by the 2b C value they carry
    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    // Guard-band symbols
    localparam logic [9:0] GB_VID_CH02 = 10'b1011001100;
    localparam logic [9:0] GB_VID_CH1  = 10'b0100110011;
    localparam logic [9:0] GB_DAT_CH12 = 10'b0100110011;

`ifdef TMDS_TERC4_EN
    // TERC4 code table, nibble 0..F
    localparam logic [9:0] TERC4_TAB [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };
`endif

    // Period code presented on the period output
    typedef enum logic [2:0] {
        P_CTRL = 3'd0,
        P_PRE  = 3'd1,
        P_VGB  = 3'd2,
        P_VID  = 3'd3,
        P_DGB  = 3'd4,
        P_DATA = 3'd5
    } period_e;

    // Tracker state; trailing data guard is its own state but reports P_DGB
    typedef enum logic [2:0] {
        S_CTRL = 3'd0,
        S_PRE  = 3'd1,
        S_VGB  = 3'd2,
        S_VID  = 3'd3,
        S_DGB  = 3'd4,
        S_DATA = 3'd5,
        S_DTRL = 3'd6
    } state_e;

    // Latched preamble type
    typedef enum logic {
        PRE_VID = 1'b0,
        PRE_DAT = 1'b1
    } pre_e;

endpackage

// File: rtl/tmds_period_decoder_sym_classify.sv
// Per-channel stage 1: registered video decode plus control/guard/TERC4 matching.
// TERC4 matching is present only when TMDS_TERC4_EN is defined.
module tmds_sym_classify
    import tmds_pkg::*;
#(
    parameter int CH = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [9:0] d,
    output logic [7:0] dec_q,
    output logic       ctrl_q,
    output logic [1:0] c_q,
    output logic       vgb_q,
    output logic       dgb_q,
    output logic       t4_q,
    output logic [3:0] nib_q
);

    logic [7:0] m;
    logic [7:0] dec_d;
    logic       ctrl_d;
    logic [1:0] c_d;
    logic       vgb_d;
    logic       dgb_d;
    logic       t4_d;
    logic [3:0] nib_d;

    // Decode and classify the incoming symbol
    always_comb begin
        m = d[9] ? ~d[7:0] : d[7:0];
        dec_d[0] = m[0];
        for (int i = 1; i < 8; i++) begin
            dec_d[i] = d[8] ? (m[i] ^ m[i-1]) : ~(m[i] ^ m[i-1]);
        end
        ctrl_d = 1'b1;
        c_d    = 2'b00;
        case (d)
            CTRL_00: c_d = 2'b00;
            CTRL_01: c_d = 2'b01;
            CTRL_10: c_d = 2'b10;
            CTRL_11: c_d = 2'b11;
            default: ctrl_d = 1'b0;
        endcase
        vgb_d = (d == ((CH == 1) ? GB_VID_CH1 : GB_VID_CH02));
        t4_d  = 1'b0;
        nib_d = 4'h0;
`ifdef TMDS_TERC4_EN
        dgb_d = (CH != 0) && (d == GB_DAT_CH12);
        for (int k = 0; k < 16; k++) begin
            if (d == TERC4_TAB[k]) begin
                t4_d  = 1'b1;
                nib_d = 4'(k);
            end
        end
`else
        dgb_d = 1'b0;
`endif
    end

    // Stage-1 register, advancing only on valid symbols
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q  <= '0;
            ctrl_q <= 1'b0;
            c_q    <= '0;
            vgb_q  <= 1'b0;
            dgb_q  <= 1'b0;
            t4_q   <= 1'b0;
            nib_q  <= '0;
        end else if (en) begin
            dec_q  <= dec_d;
            ctrl_q <= ctrl_d;
            c_q    <= c_d;
            vgb_q  <= vgb_d;
            dgb_q  <= dgb_d;
            t4_q   <= t4_d;
            nib_q  <= nib_d;
        end
    end

endmodule

// File: rtl/tmds_period_decoder.sv
// Three-channel TMDS decoder with HDMI period tracking and error counting.
// Define TMDS_TERC4_EN to enable TERC4 decode and data-island periods.
module tmds_period_decoder
    import tmds_pkg::*;
#(
    parameter int PREAMBLE_LEN = 8,
    parameter int ERRW         = 16,
    parameter int GB_LEN       = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [29:0]     d,
    output logic [23:0]     q,
    output logic [5:0]      c,
    output logic [11:0]     terc4,
    output logic [2:0]      period,
    output logic            de,
    output logic            valid,
    output logic            sym_err,
    output logic [ERRW-1:0] err_cnt,
    input  logic            clr_err
);

    localparam int CW = $clog2(PREAMBLE_LEN + 1);
    localparam int GW = $clog2(GB_LEN + 1);

    logic [23:0] s1_q;
    logic [5:0]  s1_c;
    logic [11:0] s1_nib;
    logic [2:0]  s1_ctrl, s1_vgb, s1_dgb, s1_t4;

    for (genvar g = 0; g < 3; g++) begin : g_ch
        tmds_sym_classify #(.CH(g)) u_cls (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .d      (d[10*g +: 10]),
            .dec_q  (s1_q[8*g +: 8]),
            .ctrl_q (s1_ctrl[g]),
            .c_q    (s1_c[2*g +: 2]),
            .vgb_q  (s1_vgb[g]),
            .dgb_q  (s1_dgb[g]),
            .t4_q   (s1_t4[g]),
            .nib_q  (s1_nib[4*g +: 4])
        );
    end

    state_e          st_q, st_d;
    pre_e            pre_q, pre_d, new_pre;
    period_e         period_q, wp;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   gb_q, gb_d, gb_inc;
    logic [23:0]     q_q;
    logic [5:0]      c_q;
    logic [11:0]     terc4_q;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;
    logic            v1_q, v1_d;
    logic            valid_q, valid_d;
    logic            de_q, sym_err_q;
    logic            err, adv;
    logic            vid_pre, dat_pre, is_pre;
    logic            vguard, dguard, all_ctrl;
    logic            ctrl_bad, t4_bad, cnt_full, gb_last;

    // Period tracker: classify the stage-1 word and pick the next state
    always_comb begin
        v1_d    = v1_q | en;
        adv     = en & v1_q;
        valid_d = adv;
        vid_pre = s1_ctrl[1] & s1_ctrl[2] &
                  (s1_c[3:2] == 2'b01) & (s1_c[5:4] == 2'b00);
`ifdef TMDS_TERC4_EN
        dat_pre = s1_ctrl[1] & s1_ctrl[2] &
                  (s1_c[3:2] == 2'b01) & (s1_c[5:4] == 2'b01);
        dguard  = s1_dgb[1] & s1_dgb[2];
`else
        dat_pre = 1'b0;
        dguard  = 1'b0;
`endif
        is_pre   = vid_pre | dat_pre;
        new_pre  = dat_pre ? PRE_DAT : PRE_VID;
        vguard   = &s1_vgb;
        all_ctrl = &s1_ctrl;
        ctrl_bad = |(~s1_ctrl & ~s1_vgb & ~s1_dgb);
        t4_bad   = ~&s1_t4;
        cnt_full = (cnt_q >= CW'(PREAMBLE_LEN));
        gb_inc   = gb_q + 1'b1;
        gb_last  = (gb_inc >= GW'(GB_LEN));

        st_d  = st_q;
        pre_d = pre_q;
        cnt_d = cnt_q;
        gb_d  = gb_q;
        wp    = P_CTRL;
        err   = 1'b0;

        unique case (st_q)
            S_CTRL: begin
                err = ctrl_bad;
                if (is_pre) begin
                    st_d  = S_PRE;
                    pre_d = new_pre;
                    cnt_d = CW'(1);
                    wp    = P_PRE;
                end
            end
            S_PRE: begin
                if (is_pre) begin
                    wp  = P_PRE;
                    err = ctrl_bad;
                    if (new_pre == pre_q) begin
                        cnt_d = cnt_full ? cnt_q : cnt_q + 1'b1;
                    end else begin
                        pre_d = new_pre;
                        cnt_d = CW'(1);
                    end
                end else if ((vguard && pre_q == PRE_VID) ||
                             (dguard && pre_q == PRE_DAT)) begin
                    cnt_d = '0;
                    if (cnt_full) begin
                        gb_d = GW'(1);
                        if (pre_q == PRE_VID) begin
                            wp   = P_VGB;
                            st_d = (GB_LEN <= 1) ? S_VID : S_VGB;
                        end else begin
                            wp   = P_DGB;
                            st_d = (GB_LEN <= 1) ? S_DATA : S_DGB;
                        end
                    end else begin
                        err  = 1'b1;
                        st_d = S_CTRL;
                    end
                end else begin
                    err   = ~all_ctrl;
                    cnt_d = '0;
                    st_d  = S_CTRL;
                end
            end
            S_VGB: begin
                if (vguard) begin
                    wp   = P_VGB;
                    gb_d = gb_inc;
                    if (gb_last) begin
                        gb_d = '0;
                        st_d = S_VID;
                    end
                end else begin
                    wp   = P_VID;
                    err  = 1'b1;
                    gb_d = '0;
                    st_d = S_VID;
                end
            end
            S_VID: begin
                if (s1_ctrl[0]) begin
                    st_d = S_CTRL;
                end else begin
                    wp = P_VID;
                end
            end
            S_DGB: begin
                wp   = P_DGB;
                gb_d = gb_inc;
                if (gb_last) begin
                    gb_d = '0;
                    st_d = S_DATA;
                end
            end
            S_DATA: begin
                if (dguard) begin
                    wp   = P_DGB;
                    gb_d = GW'(1);
                    st_d = (GB_LEN <= 1) ? S_CTRL : S_DTRL;
                end else begin
                    wp  = P_DATA;
                    err = t4_bad;
                end
            end
            S_DTRL: begin
                wp   = P_DGB;
                gb_d = gb_inc;
                if (gb_last) begin
                    gb_d = '0;
                    st_d = S_CTRL;
                end
            end
            default: st_d = S_CTRL;
        endcase

        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = '0;
        end else if (adv && err && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Stage-2 register: tracker state and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            valid_q   <= 1'b0;
            err_cnt_q <= '0;
            st_q      <= S_CTRL;
            pre_q     <= PRE_VID;
            cnt_q     <= '0;
            gb_q      <= '0;
            period_q  <= P_CTRL;
            de_q      <= 1'b0;
            sym_err_q <= 1'b0;
            q_q       <= '0;
            c_q       <= '0;
            terc4_q   <= '0;
        end else begin
            v1_q      <= v1_d;
            valid_q   <= valid_d;
            err_cnt_q <= err_cnt_d;
            if (adv) begin
                st_q      <= st_d;
                pre_q     <= pre_d;
                cnt_q     <= cnt_d;
                gb_q      <= gb_d;
                period_q  <= wp;
                de_q      <= (wp == P_VID);
                sym_err_q <= err;
                q_q       <= s1_q;
                c_q       <= s1_c;
                terc4_q   <= s1_nib;
            end
        end
    end

    assign q       = q_q;
    assign c       = c_q;
    assign terc4   = terc4_q;
    assign period  = period_q;
    assign de      = de_q;
    assign valid   = valid_q;
    assign sym_err = sym_err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_tmds_period_decoder.sv
// Directed self-checking bench for tmds_period_decoder (ERRW=4).
// Data-island scenario compiled only with TMDS_TERC4_EN.
module tb_tmds_period_decoder;

    localparam int ERRW = 4;

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;

    localparam logic [29:0] IDLE   = {C00, C00, C00};
    localparam logic [29:0] VPRE   = {C00, C01, C00};
    localparam logic [29:0] DPRE   = {C01, C01, C00};
    localparam logic [29:0] VGUARD = {10'b1011001100, 10'b0100110011, 10'b1011001100};
    localparam logic [29:0] DGUARD = {10'b0100110011, 10'b0100110011, 10'b1011001100};
    localparam logic [29:0] DWORD  = {10'b1001100011, 10'b1011001100, 10'b1010011100};
    localparam logic [29:0] BAD    = {3{10'b0101010101}};

    logic            clk = 1'b0;
    logic            rst, en, clr_err;
    logic [29:0]     d;
    logic [23:0]     q;
    logic [5:0]      c;
    logic [11:0]     terc4;
    logic [2:0]      period;
    logic            de, valid, sym_err;
    logic [ERRW-1:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [29:0] vw [15];
    logic [2:0]  vp [15];
    logic [7:0]  vq [15];

    tmds_period_decoder #(
        .PREAMBLE_LEN(8),
        .ERRW(ERRW),
        .GB_LEN(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .d(d),
        .q(q),
        .c(c),
        .terc4(terc4),
        .period(period),
        .de(de),
        .valid(valid),
        .sym_err(sym_err),
        .err_cnt(err_cnt),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic flush_and_clear;
        en = 1'b1;
        d = IDLE;
        repeat (3) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    // 8 preambles, 2 guards, 4 video words, 1 control word
    task automatic load_video;
        logic [9:0] vs [4];
        logic [7:0] vb [4];
        vs = '{10'h155, 10'h3AA, 10'h2AA, 10'h101};
        vb = '{8'hFF, 8'hFF, 8'h01, 8'h03};
        for (int i = 0; i < 15; i++) begin
            vq[i] = 8'h00;
            if (i < 8) begin
                vw[i] = VPRE;
                vp[i] = 3'd1;
            end else if (i < 10) begin
                vw[i] = VGUARD;
                vp[i] = 3'd2;
            end else if (i < 14) begin
                vw[i] = {3{vs[i-10]}};
                vp[i] = 3'd3;
                vq[i] = vb[i-10];
            end else begin
                vw[i] = IDLE;
                vp[i] = 3'd0;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en = 1'b1;
        clr_err = 1'b0;
        d = IDLE;
        repeat (3) tick();
        n_cmp++;
        if (period !== 3'd0) begin
            n_bad++;
            $display("FAIL rst_period got %0d want 0", period);
        end
        n_cmp++;
        if (valid !== 1'b0 || de !== 1'b0 || sym_err !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_flags got v%b d%b e%b want 000", valid, de, sym_err);
        end
        n_cmp++;
        if (q !== 24'h0 || c !== 6'h0 || terc4 !== 12'h0 || err_cnt !== '0) begin
            n_bad++;
            $display("FAIL rst_data got q%h c%h t%h e%h want 0", q, c, terc4, err_cnt);
        end
        rst = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (period !== 3'd0 || valid !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_state got p%0d v%b want p0 v1", period, valid);
        end
        n_cmp++;
        if (c !== 6'h0 || sym_err !== 1'b0 || err_cnt !== '0) begin
            n_bad++;
            $display("FAIL idle_out got c%b s%b e%0d want 0 0 0", c, sym_err, err_cnt);
        end
    endtask

    task automatic test_ctrl_values;
        d = {C10, C01, C11};
        tick();
        d = IDLE;
        tick();
        n_cmp++;
        if (c !== 6'b100111) begin
            n_bad++;
            $display("FAIL ctrl_c got %b want 100111", c);
        end
        n_cmp++;
        if (period !== 3'd0 || sym_err !== 1'b0 || terc4 !== 12'h0) begin
            n_bad++;
            $display("FAIL ctrl_misc got p%0d s%b t%h want 0 0 0", period, sym_err, terc4);
        end
        tick();
        n_cmp++;
        if (c !== 6'h0) begin
            n_bad++;
            $display("FAIL ctrl_idle_c got %b want 000000", c);
        end
    endtask

    task automatic test_video;
        load_video();
        for (int i = 0; i <= 15; i++) begin
            d = (i < 15) ? vw[i] : IDLE;
            tick();
            if (i >= 1) begin
                n_cmp++;
                if (period !== vp[i-1] || de !== (vp[i-1] == 3'd3)) begin
                    n_bad++;
                    $display("FAIL vid_period[%0d] got p%0d de%b want p%0d", i - 1, period, de, vp[i-1]);
                end
                n_cmp++;
                if (sym_err !== 1'b0 || valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL vid_flags[%0d] got s%b v%b want s0 v1", i - 1, sym_err, valid);
                end
                if (vp[i-1] == 3'd3) begin
                    n_cmp++;
                    if (q !== {3{vq[i-1]}}) begin
                        n_bad++;
                        $display("FAIL vid_q[%0d] got %h want %h", i - 1, q, {3{vq[i-1]}});
                    end
                end
            end
        end
    endtask

    task automatic test_short_preamble;
        logic [29:0] sw [7];
        logic [2:0]  sp [7];
        logic        se [7];
        flush_and_clear();
        for (int i = 0; i < 7; i++) begin
            sw[i] = (i < 5) ? VPRE : ((i == 5) ? VGUARD : IDLE);
            sp[i] = (i < 5) ? 3'd1 : 3'd0;
            se[i] = (i == 5);
        end
        for (int i = 0; i <= 7; i++) begin
            d = (i < 7) ? sw[i] : IDLE;
            tick();
            if (i >= 1) begin
                n_cmp++;
                if (period !== sp[i-1] || sym_err !== se[i-1]) begin
                    n_bad++;
                    $display("FAIL short_pre[%0d] got p%0d s%b want p%0d s%b", i - 1, period, sym_err, sp[i-1], se[i-1]);
                end
            end
        end
        n_cmp++;
        if (err_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL short_pre_cnt got %0d want 1", err_cnt);
        end
    endtask

    task automatic test_err_saturation;
        flush_and_clear();
        d = BAD;
        repeat (8) tick();
        n_cmp++;
        if (err_cnt !== 4'd7 || sym_err !== 1'b1 || period !== 3'd0) begin
            n_bad++;
            $display("FAIL sat_mid got e%0d s%b p%0d want 7 1 0", err_cnt, sym_err, period);
        end
        repeat (12) tick();
        d = IDLE;
        repeat (3) tick();
        n_cmp++;
        if (err_cnt !== 4'd15) begin
            n_bad++;
            $display("FAIL sat_cnt got %0d want 15", err_cnt);
        end
        d = BAD;
        clr_err = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (err_cnt !== 4'd0 || sym_err !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_prio got e%0d s%b want 0 1", err_cnt, sym_err);
        end
        d = IDLE;
        repeat (3) tick();
        clr_err = 1'b0;
        tick();
        n_cmp++;
        if (err_cnt !== 4'd0 || sym_err !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_after got e%0d s%b want 0 0", err_cnt, sym_err);
        end
    endtask

    task automatic test_en_gaps;
        load_video();
        for (int i = 0; i <= 15; i++) begin
            en = 1'b1;
            d = (i < 15) ? vw[i] : IDLE;
            tick();
            if (i >= 1) begin
                n_cmp++;
                if (valid !== 1'b1 || period !== vp[i-1] || de !== (vp[i-1] == 3'd3)) begin
                    n_bad++;
                    $display("FAIL gap_word[%0d] got v%b p%0d de%b want v1 p%0d", i - 1, valid, period, de, vp[i-1]);
                end
                if (vp[i-1] == 3'd3) begin
                    n_cmp++;
                    if (q !== {3{vq[i-1]}}) begin
                        n_bad++;
                        $display("FAIL gap_q[%0d] got %h want %h", i - 1, q, {3{vq[i-1]}});
                    end
                end
            end
            en = 1'b0;
            d = BAD;
            tick();
            if (i >= 1) begin
                n_cmp++;
                if (valid !== 1'b0 || period !== vp[i-1] || sym_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL gap_hold[%0d] got v%b p%0d s%b want v0 p%0d s0", i - 1, valid, period, sym_err, vp[i-1]);
                end
            end
        end
        en = 1'b1;
        d = IDLE;
        repeat (3) tick();
    endtask

`ifdef TMDS_TERC4_EN
    task automatic test_data_island;
        logic [29:0] dw [17];
        logic [2:0]  dp [17];
        for (int i = 0; i < 17; i++) begin
            if (i < 8) begin
                dw[i] = DPRE;
                dp[i] = 3'd1;
            end else if (i < 10) begin
                dw[i] = DGUARD;
                dp[i] = 3'd4;
            end else if (i < 14) begin
                dw[i] = DWORD;
                dp[i] = 3'd5;
            end else if (i < 16) begin
                dw[i] = DGUARD;
                dp[i] = 3'd4;
            end else begin
                dw[i] = IDLE;
                dp[i] = 3'd0;
            end
        end
        for (int i = 0; i <= 17; i++) begin
            d = (i < 17) ? dw[i] : IDLE;
            tick();
            if (i >= 1) begin
                n_cmp++;
                if (period !== dp[i-1] || sym_err !== 1'b0 || de !== 1'b0) begin
                    n_bad++;
                    $display("FAIL isl_period[%0d] got p%0d s%b de%b want p%0d", i - 1, period, sym_err, de, dp[i-1]);
                end
                if (dp[i-1] == 3'd5) begin
                    n_cmp++;
                    if (terc4 !== 12'h180) begin
                        n_bad++;
                        $display("FAIL isl_terc4[%0d] got %h want 180", i - 1, terc4);
                    end
                end
            end
        end
    endtask
`else
    task automatic test_dpre_plain;
        d = DPRE;
        repeat (8) tick();
        n_cmp++;
        if (period !== 3'd0 || sym_err !== 1'b0 || terc4 !== 12'h0) begin
            n_bad++;
            $display("FAIL dpre_plain got p%0d s%b t%h want 0 0 0", period, sym_err, terc4);
        end
        d = IDLE;
        repeat (3) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_ctrl_values();
        test_video();
        test_short_preamble();
        test_err_saturation();
        test_en_gaps();
`ifdef TMDS_TERC4_EN
        test_data_island();
`else
        test_dpre_plain();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
